// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: default bus widths and
// the dump engine state encoding.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  function automatic logic state_is_busy(dump_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundle of the CPU, dump-control, debug-stream and RAM-port signals around
// the data-memory controller. slave = controller side, master = environment.
interface dmem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              cpu_en;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dump_start;
  logic              dump_busy;
  logic              dump_done;

  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_valid;
  logic              dbg_last;
  logic              dbg_ready;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic              ram_en;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata, dump_start, dbg_ready, ram_dout,
    output cpu_rdata, dump_busy, dump_done, dbg_data, dbg_addr, dbg_valid, dbg_last,
           ram_addr, ram_din, ram_we, ram_en
  );

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata, dump_start, dbg_ready, ram_dout,
    input  cpu_rdata, dump_busy, dump_done, dbg_data, dbg_addr, dbg_valid, dbg_last,
           ram_addr, ram_din, ram_we, ram_en
  );
endinterface

// File: rtl/dmem_dump_fsm.sv
// Background dump engine: walks the RAM from address 0 in CPU-idle cycles and
// presents each word on a registered valid/ready stream.
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DUMP_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_cpu_en,
  input  logic [DATA_W-1:0] i_ram_dout,
  input  logic              i_dbg_ready,
  output logic              o_read,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic              o_dbg_valid,
  output logic              o_dbg_last
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DUMP_LEN - 1);

  dump_state_e       r_state;
  dump_state_e       w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;
  logic [DATA_W-1:0] r_dbg_data;
  logic [ADDR_W-1:0] r_dbg_addr;
  logic              r_dbg_valid;
  logic              r_dbg_last;
  logic              w_capture;
  logic              w_accept;

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_READ;
          w_ptr_next   = '0;
        end
      end
      // The CPU owns the RAM port whenever it asks; the read simply retries.
      ST_READ: begin
        if (!i_cpu_en) begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_dbg_ready) begin
          w_accept = 1'b1;
          if (r_dbg_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_ptr_next   = r_ptr + ADDR_W'(1);
            w_state_next = ST_READ;
          end
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_dbg_data  <= '0;
      r_dbg_addr  <= '0;
      r_dbg_valid <= 1'b0;
      r_dbg_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_capture) begin
        r_dbg_data  <= i_ram_dout;
        r_dbg_addr  <= r_ptr;
        r_dbg_valid <= 1'b1;
        r_dbg_last  <= (r_ptr == LAST_PTR);
      end else if (w_accept) begin
        r_dbg_valid <= 1'b0;
        r_dbg_last  <= 1'b0;
      end
    end
  end

  assign o_read      = (r_state == ST_READ);
  assign o_ptr       = r_ptr;
  assign o_busy      = state_is_busy(r_state);
  assign o_done      = (r_state == ST_DONE);
  assign o_dbg_data  = r_dbg_data;
  assign o_dbg_addr  = r_dbg_addr;
  assign o_dbg_valid = r_dbg_valid;
  assign o_dbg_last  = r_dbg_last;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: CPU has fixed priority on the single RAM
// port; the dump engine borrows idle cycles for read-only streaming.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DUMP_LEN = 1024
) (
  input logic       clk,
  input logic       rst_n,
  dmem_ctrl_if.slave bus
);

  logic              w_read;
  logic [ADDR_W-1:0] w_ptr;

  dmem_dump_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DUMP_LEN (DUMP_LEN)
  ) u_dump (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (bus.dump_start),
    .i_cpu_en    (bus.cpu_en),
    .i_ram_dout  (bus.ram_dout),
    .i_dbg_ready (bus.dbg_ready),
    .o_read      (w_read),
    .o_ptr       (w_ptr),
    .o_busy      (bus.dump_busy),
    .o_done      (bus.dump_done),
    .o_dbg_data  (bus.dbg_data),
    .o_dbg_addr  (bus.dbg_addr),
    .o_dbg_valid (bus.dbg_valid),
    .o_dbg_last  (bus.dbg_last)
  );

  // Only the CPU branch can raise ram_we; the dump path is read-only.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    bus.ram_we   = 1'b0;
    bus.ram_en   = 1'b0;
    if (bus.cpu_en) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_din  = bus.cpu_wdata;
      bus.ram_we   = bus.cpu_we;
      bus.ram_en   = 1'b1;
    end else if (w_read) begin
      bus.ram_addr = w_ptr;
      bus.ram_en   = 1'b1;
    end
  end

  assign bus.cpu_rdata = bus.ram_dout;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with an 8-word dump and a negedge RAM model.
module tb_dmem_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DUMP_LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // RAM model: registered read and write commit on the falling edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          do_preload = 1'b0;
  always @(negedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i + 128);
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  // Stream log: a handshake seen at a negedge completes at the next posedge.
  int            cyc = 0;
  int            log_n = 0;
  int            done_cnt = 0;
  int            done_at = 0;
  int            valid_cyc = 0;
  logic [AW-1:0] log_addr [256];
  logic [DW-1:0] log_data [256];
  logic          log_last [256];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.dbg_valid) valid_cyc++;
    if (bus.dbg_valid && bus.dbg_ready && log_n < 256) begin
      log_addr[log_n] = bus.dbg_addr;
      log_data[log_n] = bus.dbg_data;
      log_last[log_n] = bus.dbg_last;
      log_n++;
    end
    if (bus.dump_done) begin
      done_cnt++;
      done_at = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    do_preload = 1'b1;
    @(negedge clk);
    #1;
    do_preload = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int i = 0; i < budget && done_cnt == base; i++) tick();
  endtask

  task automatic wait_read_at(input int base, input int words);
    for (int i = 0; i < 40; i++) begin
      if (log_n - base == words && !bus.dbg_valid) break;
      tick();
    end
  endtask

  task automatic test_reset();
    int vc, dc;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.dbg_valid, bus.dbg_last, bus.dump_busy, bus.dump_done, bus.ram_en, bus.ram_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000", {bus.dbg_valid, bus.dbg_last, bus.dump_busy,
               bus.dump_done, bus.ram_en, bus.ram_we});
    end
    checks++;
    if (bus.dbg_data !== '0 || bus.dbg_addr !== '0 || bus.ram_addr !== '0 || bus.ram_din !== '0) begin
      failures++;
      $display("FAIL reset_buses data=%h addr=%h ram_addr=%h ram_din=%h want all 0",
               bus.dbg_data, bus.dbg_addr, bus.ram_addr, bus.ram_din);
    end
    rst_n = 1'b1;
    tick();
    preload();
    bus.dbg_ready = 1'b0;
    pulse_start();
    tick();
    checks++;
    if (bus.dbg_valid !== 1'b1 || bus.dbg_data !== 32'd128) begin
      failures++;
      $display("FAIL hold_before_reset valid=%b data=%0d want valid=1 data=128", bus.dbg_valid, bus.dbg_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dbg_valid, bus.dbg_last, bus.dump_busy, bus.dump_done, bus.ram_en} !== 5'b0 ||
        bus.dbg_data !== '0 || bus.dbg_addr !== '0) begin
      failures++;
      $display("FAIL async_reset flags=%b data=%h addr=%h want all 0",
               {bus.dbg_valid, bus.dbg_last, bus.dump_busy, bus.dump_done, bus.ram_en}, bus.dbg_data, bus.dbg_addr);
    end
    rst_n = 1'b1;
    tick();
    vc = valid_cyc;
    dc = done_cnt;
    bus.dbg_ready = 1'b1;
    repeat (20) tick();
    checks++;
    if (valid_cyc !== vc || done_cnt !== dc) begin
      failures++;
      $display("FAIL after_abort valid_cycles=%0d done=%0d want 0 and 0", valid_cyc - vc, done_cnt - dc);
    end
    $display("reset test done");
  endtask

  task automatic test_cpu();
    bus.cpu_en = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'd5; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_addr !== 10'd5 || bus.ram_din !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cpu_store_port we=%b en=%b addr=%0d din=%h want 1 1 5 deadbeef",
               bus.ram_we, bus.ram_en, bus.ram_addr, bus.ram_din);
    end
    tick();
    bus.cpu_we = 1'b0;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0) begin
      failures++;
      $display("FAIL cpu_load_we got=%b want=0", bus.ram_we);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cpu_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cpu_load5 got=%h want=deadbeef", bus.cpu_rdata);
    end
    @(posedge clk); #1;
    bus.cpu_addr = 10'd7;
    @(negedge clk); #1;
    checks++;
    if (bus.cpu_rdata !== 32'd135) begin
      failures++;
      $display("FAIL cpu_load7 got=%0d want=135", bus.cpu_rdata);
    end
    @(posedge clk); #1;
    bus.cpu_en = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    #1;
    checks++;
    if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin
      failures++;
      $display("FAIL cpu_idle_port en=%b we=%b want 0 0", bus.ram_en, bus.ram_we);
    end
    tick();
    $display("cpu test done");
  endtask

  task automatic test_full_dump();
    int b, d, s;
    preload();
    bus.dbg_ready = 1'b1;
    b = log_n; d = done_cnt; s = cyc;
    pulse_start();
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.dump_busy !== 1'b1) begin
      failures++;
      $display("FAIL dump_first_read en=%b we=%b addr=%0d busy=%b want 1 0 0 1",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.dump_busy);
    end
    wait_done(d, 40);
    repeat (3) tick();
    checks++;
    if (log_n - b !== LEN) begin
      failures++;
      $display("FAIL full_count got=%0d want=%0d", log_n - b, LEN);
    end
    for (int k = 0; k < LEN; k++) begin
      checks++;
      if (log_addr[b+k] !== AW'(k) || log_data[b+k] !== DW'(k + 128) || log_last[b+k] !== (k == LEN - 1)) begin
        failures++;
        $display("FAIL full_word%0d got addr=%0d data=%0d last=%b want addr=%0d data=%0d last=%b",
                 k, log_addr[b+k], log_data[b+k], log_last[b+k], k, k + 128, k == LEN - 1);
      end
    end
    checks++;
    if (done_cnt - d !== 1 || done_at - s !== 17) begin
      failures++;
      $display("FAIL full_done pulses=%0d latency=%0d want 1 and 17", done_cnt - d, done_at - s);
    end
    $display("full dump done words=%0d", log_n - b);
  endtask

  task automatic test_contention();
    int b, d;
    preload();
    bus.dbg_ready = 1'b1;
    b = log_n; d = done_cnt;
    pulse_start();
    wait_read_at(b, 3);
    bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd100;
    #1;
    checks++;
    if (bus.ram_addr !== 10'd100) begin
      failures++;
      $display("FAIL contention_mux got=%0d want=100", bus.ram_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.dbg_valid !== 1'b0) begin
        failures++;
        $display("FAIL contention_stall%0d valid got=%b want=0", i, bus.dbg_valid);
      end
    end
    bus.cpu_en = 1'b0; bus.cpu_addr = '0;
    tick();
    checks++;
    if (bus.dbg_valid !== 1'b1 || bus.dbg_addr !== 10'd3 || bus.dbg_data !== 32'd131) begin
      failures++;
      $display("FAIL contention_resume valid=%b addr=%0d data=%0d want 1 3 131",
               bus.dbg_valid, bus.dbg_addr, bus.dbg_data);
    end
    wait_done(d, 40);
    tick();
    checks++;
    if (log_n - b !== LEN || done_cnt - d !== 1) begin
      failures++;
      $display("FAIL contention_count words=%0d done=%0d want %0d 1", log_n - b, done_cnt - d, LEN);
    end
    for (int k = 0; k < LEN; k++) begin
      checks++;
      if (log_addr[b+k] !== AW'(k) || log_data[b+k] !== DW'(k + 128)) begin
        failures++;
        $display("FAIL contention_word%0d got addr=%0d data=%0d want %0d %0d",
                 k, log_addr[b+k], log_data[b+k], k, k + 128);
      end
    end
    $display("contention dump done words=%0d", log_n - b);
  endtask

  task automatic test_backpressure();
    int b, d;
    preload();
    bus.dbg_ready = 1'b1;
    b = log_n; d = done_cnt;
    pulse_start();
    wait_read_at(b, 4);
    bus.dbg_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.dbg_valid !== 1'b1 || bus.dbg_addr !== 10'd4 || bus.dbg_data !== 32'd132) begin
        failures++;
        $display("FAIL backpressure%0d valid=%b addr=%0d data=%0d want 1 4 132",
                 i, bus.dbg_valid, bus.dbg_addr, bus.dbg_data);
      end
      tick();
    end
    checks++;
    if (log_n - b !== 4) begin
      failures++;
      $display("FAIL backpressure_accepted words=%0d want=4", log_n - b);
    end
    bus.dbg_ready = 1'b1;
    wait_done(d, 40);
    tick();
    checks++;
    if (log_n - b !== LEN || log_addr[b+4] !== 10'd4 || log_data[b+4] !== 32'd132 || log_addr[b+5] !== 10'd5) begin
      failures++;
      $display("FAIL backpressure_stream words=%0d w4=%0d/%0d w5addr=%0d want %0d 4/132 5",
               log_n - b, log_addr[b+4], log_data[b+4], log_addr[b+5], LEN);
    end
    $display("backpressure dump done words=%0d", log_n - b);
  endtask

  task automatic test_store_during_dump();
    int b, d;
    logic [DW-1:0] exp;
    preload();
    bus.dbg_ready = 1'b1;
    b = log_n; d = done_cnt;
    pulse_start();
    wait_read_at(b, 2);
    bus.cpu_en = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'd6; bus.cpu_wdata = 32'h1;
    bus.dump_start = 1'b1;
    tick();
    bus.cpu_en = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dump_start = 1'b0;
    checks++;
    if (bus.dump_busy !== 1'b1) begin
      failures++;
      $display("FAIL store_busy got=%b want=1", bus.dump_busy);
    end
    wait_done(d, 40);
    repeat (10) tick();
    checks++;
    if (log_n - b !== LEN || done_cnt - d !== 1 || bus.dump_busy !== 1'b0) begin
      failures++;
      $display("FAIL store_count words=%0d done=%0d busy=%b want %0d 1 0",
               log_n - b, done_cnt - d, bus.dump_busy, LEN);
    end
    for (int k = 0; k < LEN; k++) begin
      exp = (k == 6) ? 32'h1 : DW'(k + 128);
      checks++;
      if (log_addr[b+k] !== AW'(k) || log_data[b+k] !== exp) begin
        failures++;
        $display("FAIL store_word%0d got addr=%0d data=%h want %0d %h", k, log_addr[b+k], log_data[b+k], k, exp);
      end
    end
    $display("store-during-dump done words=%0d", log_n - b);
  endtask

  initial begin
    bus.cpu_en = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dump_start = 1'b0; bus.dbg_ready = 1'b0;
    test_reset();
    test_cpu();
    test_full_dump();
    test_contention();
    test_backpressure();
    test_store_during_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
